// File: rtl/branch_predict_unit_pkg.sv
// Shared constants and counter helper for the branch predict unit.
package branch_predict_unit_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    // Saturating 2-bit counter transition on a resolved outcome.
    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        case (cnt)
            CNT_SNT: nxt = taken ? CNT_WNT : CNT_SNT;
            CNT_WNT: nxt = taken ? CNT_WT  : CNT_SNT;
            CNT_WT:  nxt = taken ? CNT_ST  : CNT_WNT;
            CNT_ST:  nxt = taken ? CNT_ST  : CNT_WT;
            default: nxt = cnt;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_compare.sv
// Combinational RV32I/RV64I conditional-branch comparator.
module branch_compare
    import branch_predict_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            cmp_result,
    output logic            funct3_legal
);

    always_comb begin
        cmp_result   = 1'b0;
        funct3_legal = 1'b1;
        case (funct3)
            F3_BEQ:  cmp_result = (rs1 == rs2);
            F3_BNE:  cmp_result = (rs1 != rs2);
            F3_BLT:  cmp_result = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  cmp_result = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: cmp_result = (rs1 <  rs2);
            F3_BGEU: cmp_result = (rs1 >= rs2);
            default: funct3_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolve + BHT (2-bit counters) predictor with optional stats.
// Optional counters enabled by defining BRANCH_PREDICT_STATS_EN.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_DEPTH = 64,
    parameter logic [1:0]  CNT_INIT  = 2'b01
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_taken,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_stall,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic            ex_pred_taken,
    output logic            branch_taken,
    output logic            mispredict,
    output logic [31:0]     br_count,
    output logic [31:0]     mp_count
);

    localparam int unsigned IDX = $clog2(BHT_DEPTH);

    logic [1:0]     bht [BHT_DEPTH];
    logic [IDX-1:0] fetch_idx;
    logic [IDX-1:0] ex_idx;
    logic           cmp_result;
    logic           funct3_legal;
    logic           resolve;
    logic           unused_pc_bits;

    assign fetch_idx = fetch_pc[IDX+1:2];
    assign ex_idx    = ex_pc[IDX+1:2];

    // Untagged table: only the index bits of either PC participate.
    assign unused_pc_bits = ^{fetch_pc[XLEN-1:IDX+2], fetch_pc[1:0],
                              ex_pc[XLEN-1:IDX+2], ex_pc[1:0]};

    branch_compare #(.XLEN(XLEN)) u_cmp (
        .funct3       (ex_funct3),
        .rs1          (ex_rs1),
        .rs2          (ex_rs2),
        .cmp_result   (cmp_result),
        .funct3_legal (funct3_legal)
    );

    assign resolve      = ex_valid & ex_is_branch & ~ex_stall & funct3_legal;
    assign branch_taken = resolve & cmp_result;
    assign mispredict   = resolve & (cmp_result != ex_pred_taken);

    // No bypass: a same-cycle fetch of the written index sees the old counter.
    assign pred_taken = bht[fetch_idx][1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= CNT_INIT;
            end
        end else if (resolve) begin
            bht[ex_idx] <= cnt_next(bht[ex_idx], cmp_result);
        end
    end

`ifdef BRANCH_PREDICT_STATS_EN
    // Statistics saturate rather than wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_count <= 32'd0;
            mp_count <= 32'd0;
        end else begin
            if (resolve && (br_count != 32'hFFFF_FFFF)) begin
                br_count <= br_count + 32'd1;
            end
            if (mispredict && (mp_count != 32'hFFFF_FFFF)) begin
                mp_count <= mp_count + 32'd1;
            end
        end
    end
`else
    assign br_count = 32'd0;
    assign mp_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: vector table, directed corners, random vs. model.
module tb_branch_predict_unit;

    localparam int DEPTH = 64;
`ifdef BRANCH_PREDICT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic        ex_valid, ex_is_branch, ex_stall, ex_pred_taken;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc, ex_rs1, ex_rs2;
    logic        branch_taken, mispredict;
    logic [31:0] br_count, mp_count;

    branch_predict_unit dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_pc      (fetch_pc),
        .pred_taken    (pred_taken),
        .ex_valid      (ex_valid),
        .ex_is_branch  (ex_is_branch),
        .ex_stall      (ex_stall),
        .ex_funct3     (ex_funct3),
        .ex_pc         (ex_pc),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .ex_pred_taken (ex_pred_taken),
        .branch_taken  (branch_taken),
        .mispredict    (mispredict),
        .br_count      (br_count),
        .mp_count      (mp_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: counter value 0..3 per entry and plain event totals.
    int          m_cnt [DEPTH];
    int unsigned m_br;
    int unsigned m_mp;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_index(input logic [31:0] pc);
        return int'((pc / 4) % DEPTH);
    endfunction

    function automatic bit m_legal(input logic [2:0] f);
        return !(f == 3'd2 || f == 3'd3);
    endfunction

    function automatic bit m_cond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (f)
            3'd0: return ua == ub;
            3'd1: return ua != ub;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return ua < ub;
            3'd7: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_resolve();
        return ex_valid && ex_is_branch && !ex_stall && m_legal(ex_funct3);
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_cnt[m_index(pc)] >= 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_cnt[i] = 1;
        m_br = 0;
        m_mp = 0;
    endtask

    task automatic drive_idle(input logic [31:0] fpc);
        fetch_pc      = fpc;
        ex_valid      = 1'b0;
        ex_is_branch  = 1'b0;
        ex_stall      = 1'b0;
        ex_funct3     = 3'd0;
        ex_pc         = 32'd0;
        ex_rs1        = 32'd0;
        ex_rs2        = 32'd0;
        ex_pred_taken = 1'b0;
    endtask

    task automatic drive_br(input logic [31:0] fpc, input logic [31:0] pc, input logic [2:0] f,
                            input logic [31:0] a, input logic [31:0] b, input logic pt,
                            input logic stall);
        fetch_pc      = fpc;
        ex_valid      = 1'b1;
        ex_is_branch  = 1'b1;
        ex_stall      = stall;
        ex_funct3     = f;
        ex_pc         = pc;
        ex_rs1        = a;
        ex_rs2        = b;
        ex_pred_taken = pt;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic check_model(input string tag);
        bit res, cond;
        res  = m_resolve();
        cond = m_cond(ex_funct3, ex_rs1, ex_rs2);
        check({tag, ".pred"}, 32'(pred_taken), 32'(m_pred(fetch_pc)));
        check({tag, ".taken"}, 32'(branch_taken), 32'(res && cond));
        check({tag, ".mispredict"}, 32'(mispredict), 32'(res && (cond != ex_pred_taken)));
        check({tag, ".br_count"}, br_count, STATS ? m_br : 32'd0);
        check({tag, ".mp_count"}, mp_count, STATS ? m_mp : 32'd0);
    endtask

    task automatic tick();
        bit res, cond;
        int ix;
        res  = m_resolve();
        cond = m_cond(ex_funct3, ex_rs1, ex_rs2);
        ix   = m_index(ex_pc);
        @(posedge clk);
        if (res && !reset) begin
            m_cnt[ix] = cond ? ((m_cnt[ix] == 3) ? 3 : m_cnt[ix] + 1)
                             : ((m_cnt[ix] == 0) ? 0 : m_cnt[ix] - 1);
            if (m_br != 32'hFFFF_FFFF) m_br++;
            if (cond != ex_pred_taken && m_mp != 32'hFFFF_FFFF) m_mp++;
        end
        #1;
    endtask

    task automatic cycle(input string tag);
        settle();
        check_model(tag);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_idle(32'h100);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        exp_taken;
        logic        exp_mp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{3'b100, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1};
        vecs[1] = '{3'b110, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0};
        vecs[2] = '{3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0};
        vecs[3] = '{3'b111, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1};
        vecs[4] = '{3'b000, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0};
        vecs[5] = '{3'b001, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1};
        vecs[6] = '{3'b010, 32'd7,         32'd7, 1'b0, 1'b0};
        vecs[7] = '{3'b011, 32'd7,         32'd7, 1'b0, 1'b0};

        reset = 1'b1;
        drive_idle(32'h100);
        model_reset();
        do_reset();

        // Reset state
        settle();
        check("reset.pred", 32'(pred_taken), 32'd0);
        check("reset.br", br_count, 32'd0);
        check("reset.mp", mp_count, 32'd0);
        check_model("reset");
        tick();

        // Compare sweep
        for (int i = 0; i < 8; i++) begin
            drive_br(32'h100, 32'h40 + 32'(i) * 32'd4, vecs[i].f3, vecs[i].rs1, vecs[i].rs2, 1'b0, 1'b0);
            settle();
            check($sformatf("sweep%0d.taken", i), 32'(branch_taken), 32'(vecs[i].exp_taken));
            check($sformatf("sweep%0d.mp", i), 32'(mispredict), 32'(vecs[i].exp_mp));
            check_model($sformatf("sweep%0d", i));
            tick();
        end

        // Training at 0x200
        do_reset();
        drive_br(32'h200, 32'h200, 3'b000, 32'd5, 32'd5, 1'b0, 1'b0);
        settle();
        check("train1.mp", 32'(mispredict), 32'd1);
        check("train1.pred_before", 32'(pred_taken), 32'd0);
        check_model("train1");
        tick();
        drive_idle(32'h200);
        settle();
        check("train1.pred_after", 32'(pred_taken), 32'd1);
        check_model("train1i");
        tick();
        for (int i = 0; i < 2; i++) begin
            drive_br(32'h200, 32'h200, 3'b000, 32'd5, 32'd5, 1'b0, 1'b0);
            cycle("train2");
        end
        drive_br(32'h200, 32'h200, 3'b001, 32'd5, 32'd5, 1'b1, 1'b0);
        cycle("train_nt1");
        drive_idle(32'h200);
        settle();
        check("train.wt_pred", 32'(pred_taken), 32'd1);
        tick();
        drive_br(32'h200, 32'h200, 3'b001, 32'd5, 32'd5, 1'b1, 1'b0);
        cycle("train_nt2");
        drive_idle(32'h200);
        settle();
        check("train.wnt_pred", 32'(pred_taken), 32'd0);
        tick();

        // Same-cycle update and lookup of index 5
        drive_br(32'h14, 32'h14, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
        settle();
        check("hazard.same_cycle", 32'(pred_taken), 32'd0);
        check_model("hazard");
        tick();
        drive_idle(32'h14);
        settle();
        check("hazard.next_cycle", 32'(pred_taken), 32'd1);
        tick();

        // Stall and illegal funct3 must not resolve or train
        drive_br(32'h300, 32'h300, 3'b000, 32'd9, 32'd9, 1'b0, 1'b1);
        settle();
        check("stall.taken", 32'(branch_taken), 32'd0);
        check_model("stall");
        tick();
        drive_br(32'h300, 32'h300, 3'b010, 32'd9, 32'd9, 1'b0, 1'b0);
        settle();
        check("illegal.taken", 32'(branch_taken), 32'd0);
        check_model("illegal");
        tick();
        drive_br(32'h300, 32'h304, 3'b000, 32'd9, 32'd9, 1'b0, 1'b0);
        ex_valid = 1'b0;
        cycle("invalid");
        drive_idle(32'h300);
        settle();
        check("stall.pred_unchanged", 32'(pred_taken), 32'd0);
        check_model("stall_after");
        tick();

        // Mid-stream reset after training index 7 to ST
        for (int i = 0; i < 3; i++) begin
            drive_br(32'h1C, 32'h1C, 3'b111, 32'd3, 32'd3, 1'b0, 1'b0);
            cycle("pre_reset");
        end
        drive_br(32'h1C, 32'h1C, 3'b111, 32'd3, 32'd3, 1'b1, 1'b0);
        settle();
        check("pre_reset.pred", 32'(pred_taken), 32'd1);
        reset = 1'b1;
        model_reset();
        #1;
        check("async_reset.pred", 32'(pred_taken), 32'd0);
        check("async_reset.br", br_count, 32'd0);
        check("async_reset.mp", mp_count, 32'd0);
        tick();
        drive_idle(32'h1C);
        reset = 1'b0;
        cycle("post_reset");
        drive_br(32'h1C, 32'h1C, 3'b111, 32'd3, 32'd3, 1'b0, 1'b0);
        cycle("restart");
        drive_idle(32'h1C);
        settle();
        check("restart.from_wnt", 32'(pred_taken), 32'd1);
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a, b, pc;
            int sel;
            a   = $urandom;
            sel = $urandom_range(0, 3);
            case (sel)
                0: b = a;
                1: begin a = 32'($urandom_range(0, 7)); b = 32'($urandom_range(0, 7)); end
                2: b = $urandom;
                default: begin a = 32'h8000_0000; b = 32'($urandom_range(0, 1)) << 31; end
            endcase
            pc = (32'($urandom_range(0, 15)) << 2) | (($urandom & 32'h1) << 8);
            drive_br(32'($urandom_range(0, 15)) << 2, pc, 3'($urandom_range(0, 7)), a, b,
                     ($urandom_range(0, 1) == 1) ? m_pred(pc) : 1'($urandom), 1'b0);
            ex_valid     = ($urandom_range(0, 7) != 0);
            ex_is_branch = ($urandom_range(0, 7) != 0);
            ex_stall     = ($urandom_range(0, 7) == 0);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch unit for the pipelined RISC-V core. It resolves all six RV32I/RV64I conditional branches in the execute stage and predicts fetch-stage branches from a PC-indexed branch history table of 2-bit saturating counters. It trains the table on every resolved branch and flags mispredictions for the hazard/flush logic.

## Interface
- XLEN, 32, operand and PC width
- BHT_DEPTH, 64, table entries; power of two, at least 2
- CNT_INIT, 2'b01, reset value of every counter (weakly not-taken)

- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high
- fetch_pc  in  XLEN  PC being fetched
- pred_taken  out  1  prediction for fetch_pc
- ex_valid  in  1  execute stage holds a valid instruction
- ex_is_branch  in  1  instruction is a conditional branch
- ex_stall  in  1  execute stage frozen this cycle
- ex_funct3  in  3  branch funct3
- ex_pc  in  XLEN  PC of the executing branch
- ex_rs1, ex_rs2  in  XLEN  operands
- ex_pred_taken  in  1  prediction piped from fetch
- branch_taken  out  1  resolved outcome
- mispredict  out  1  outcome differs from prediction
- br_count  out  32  resolved branches (stats)
- mp_count  out  32  mispredictions (stats)

## Operation
- Index is pc[IDX+1:2], with IDX = log2(BHT_DEPTH). There are no tags, so aliasing is accepted.
- pred_taken = bht[idx(fetch_pc)][1]. This is a combinational read of registered state.
- Compare rules:
  - 000 beq: rs1 == rs2
  - 001 bne: rs1 != rs2
  - 100 blt: signed rs1 < rs2
  - 101 bge: signed rs1 >= rs2
  - 110 bltu: unsigned rs1 < rs2
  - 111 bgeu: unsigned rs1 >= rs2
  - 010 and 011: not-taken, and the branch counts as invalid.
- resolve = ex_valid & ex_is_branch & !ex_stall & legal funct3.
- branch_taken = resolve & cmp_result. When resolve is 0, branch_taken is 0.
- mispredict = resolve & (cmp_result != ex_pred_taken).
- Counter FSM states are SNT=00, WNT=01, WT=10, ST=11.
  - Taken: increment, saturating at ST.
  - Not-taken: decrement, saturating at SNT.
  - Update happens only when resolve is 1. Exactly one entry changes per cycle.
- Illegal funct3, ex_stall, or !ex_valid cause no update and leave the counters unchanged.

## Timing
- Reset, applied asynchronously:
  - Every counter is set to CNT_INIT, so pred_taken = CNT_INIT[1], which is 0 by default.
  - br_count and mp_count are set to 0.
  - branch_taken and mispredict are combinational, so they are 0 whenever ex inputs are idle.
- Prediction latency is 0 cycles. Resolution latency is 0 cycles (combinational in execute).
- The table write takes effect at the rising clk after resolve. A fetch lookup of the same index in that same cycle sees the old value; there is no bypass.
- Two back-to-back branches on the same index: the second sees the counter already updated by the first.
- Reset asserted mid-operation discards any pending update in that cycle. Training restarts from CNT_INIT.

## Configuration
- BRANCH_PREDICT_STATS_EN defined:
  - br_count increments on each resolve.
  - mp_count increments on each mispredict.
  - Both are 32-bit and saturate at 32'hFFFF_FFFF with no wrap.
- Not defined: the counters are not synthesised and both ports are tied to 0. The ports are always present.

## Structure
- Shared package holds:
  - funct3 constants F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - Counter state constants CNT_SNT, CNT_WNT, CNT_WT, CNT_ST.
- Sub-module branch_compare, combinational:
  - Inputs funct3, rs1, rs2, parameter XLEN.
  - Outputs cmp_result and funct3_legal.
- The table and FSM update stay in the top module.

## Test plan
- Reset, then fetch_pc = 0x100: pred_taken = 0. With the stats macro defined, both counters read 0.
- Compare sweep with rs1 = 32'hFFFF_FFFF and rs2 = 1:
  - blt taken, bltu not-taken.
  - bge not-taken, bgeu taken.
  - beq not-taken, bne taken.
- Training on pc 0x200, ex_pred_taken = 0:
  - First taken resolve: mispredict = 1. Next cycle, pred_taken at 0x200 = 1.
  - Two more taken resolves: counter = ST. One not-taken resolve: counter = WT, pred_taken still 1.
- Same-cycle hazard: update idx 5 to taken while fetch_pc hits idx 5. pred_taken is 0 that cycle and 1 the next.
- ex_stall = 1, or funct3 = 010, with a taken condition: branch_taken = 0, no counter change, br_count unchanged.
- Reset asserted mid-stream after training to ST: all entries return to WNT and pred_taken = 0 immediately.
